// File: rtl/mem_bus_arbiter.sv
// Three-master memory bus arbiter: the walker has fixed priority, and the CPU data and instruction ports take turns round-robin.
// Optional bus timeout: define ARB_TIMEOUT_EN to abort a BUSY transaction after TIMEOUT cycles without ack_i.
module mem_bus_arbiter #(
    parameter int TIMEOUT = 255,
    parameter bit RR_INIT = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] w_addr_i,
    input  logic        w_rd_i,
    output logic        w_ack_o,
    input  logic [31:0] i_addr_i,
    input  logic        i_rd_i,
    output logic        i_ack_o,
    input  logic [31:0] d_addr_i,
    input  logic [31:0] d_data_i,
    input  logic        d_rd_i,
    input  logic        d_we_i,
    output logic        d_ack_o,
    output logic [31:0] rdata_o,
    output logic [31:0] addr_o,
    output logic [31:0] data_o,
    input  logic [31:0] data_i,
    output logic        rd_o,
    output logic        we_o,
    input  logic        ack_i,
    output logic [1:0]  grant_o,
    output logic        err_o
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_W    = 2'b01;
    localparam logic [1:0] GNT_D    = 2'b10;
    localparam logic [1:0] GNT_I    = 2'b11;

    state_t      state, state_next;
    logic [31:0] addr_next, data_next, rdata_next;
    logic        rd_next, we_next;
    logic        w_ack_next, d_ack_next, i_ack_next;
    logic [1:0]  grant_next;
    // rr = 0 favours the data port, rr = 1 favours the instruction port
    logic        rr, rr_next;
    logic        d_req, i_req;
    logic        finish;

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             err_next;
    logic             expired;

    assign expired = (cnt == CNT_W'(TIMEOUT - 1));
`endif

    assign d_req = d_rd_i | d_we_i;
    assign i_req = i_rd_i;

    always_comb begin
        state_next = state;
        addr_next  = addr_o;
        data_next  = data_o;
        rdata_next = rdata_o;
        rd_next    = rd_o;
        we_next    = we_o;
        grant_next = grant_o;
        rr_next    = rr;
        w_ack_next = 1'b0;
        d_ack_next = 1'b0;
        i_ack_next = 1'b0;
        finish     = 1'b0;
`ifdef ARB_TIMEOUT_EN
        cnt_next   = cnt;
        err_next   = 1'b0;
`endif
        case (state)
            IDLE: begin
`ifdef ARB_TIMEOUT_EN
                cnt_next = '0;
`endif
                if (w_rd_i) begin
                    addr_next  = w_addr_i;
                    data_next  = 32'h0;
                    rd_next    = 1'b1;
                    we_next    = 1'b0;
                    grant_next = GNT_W;
                    state_next = BUSY;
                end else if (d_req && (!i_req || !rr)) begin
                    // A simultaneous read+write request is treated as a write
                    addr_next  = d_addr_i;
                    data_next  = d_data_i;
                    rd_next    = ~d_we_i;
                    we_next    = d_we_i;
                    grant_next = GNT_D;
                    state_next = BUSY;
                end else if (i_req) begin
                    addr_next  = i_addr_i;
                    data_next  = 32'h0;
                    rd_next    = 1'b1;
                    we_next    = 1'b0;
                    grant_next = GNT_I;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (ack_i) begin
                    rdata_next = data_i;
                    finish     = 1'b1;
                end
`ifdef ARB_TIMEOUT_EN
                else if (expired) begin
                    rdata_next = 32'h0;
                    err_next   = 1'b1;
                    finish     = 1'b1;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
`endif
                if (finish) begin
                    rd_next    = 1'b0;
                    we_next    = 1'b0;
                    w_ack_next = (grant_o == GNT_W);
                    d_ack_next = (grant_o == GNT_D);
                    i_ack_next = (grant_o == GNT_I);
                    state_next = DONE;
                end
            end
            DONE: begin
                grant_next = GNT_NONE;
                state_next = IDLE;
                if (grant_o == GNT_D) begin
                    rr_next = 1'b1;
                end else if (grant_o == GNT_I) begin
                    rr_next = 1'b0;
                end
            end
            default: begin
                state_next = IDLE;
                grant_next = GNT_NONE;
                rd_next    = 1'b0;
                we_next    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            addr_o  <= 32'h0;
            data_o  <= 32'h0;
            rdata_o <= 32'h0;
            rd_o    <= 1'b0;
            we_o    <= 1'b0;
            grant_o <= GNT_NONE;
            rr      <= RR_INIT;
            w_ack_o <= 1'b0;
            d_ack_o <= 1'b0;
            i_ack_o <= 1'b0;
        end else begin
            state   <= state_next;
            addr_o  <= addr_next;
            data_o  <= data_next;
            rdata_o <= rdata_next;
            rd_o    <= rd_next;
            we_o    <= we_next;
            grant_o <= grant_next;
            rr      <= rr_next;
            w_ack_o <= w_ack_next;
            d_ack_o <= d_ack_next;
            i_ack_o <= i_ack_next;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            err_o <= 1'b0;
        end else begin
            cnt   <= cnt_next;
            err_o <= err_next;
        end
    end
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: walker priority, d/i round-robin, write path, reset abort, and the timeout path.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] w_addr_i, i_addr_i, d_addr_i, d_data_i, data_i;
    logic        w_rd_i, i_rd_i, d_rd_i, d_we_i, ack_i;
    logic        w_ack_o, i_ack_o, d_ack_o, rd_o, we_o, err_o;
    logic [31:0] rdata_o, addr_o, data_o;
    logic [1:0]  grant_o;

    int total = 0;
    int bad   = 0;

    mem_bus_arbiter #(.TIMEOUT(4), .RR_INIT(1'b0)) dut (
        .clk(clk), .rst(rst),
        .w_addr_i(w_addr_i), .w_rd_i(w_rd_i), .w_ack_o(w_ack_o),
        .i_addr_i(i_addr_i), .i_rd_i(i_rd_i), .i_ack_o(i_ack_o),
        .d_addr_i(d_addr_i), .d_data_i(d_data_i), .d_rd_i(d_rd_i), .d_we_i(d_we_i),
        .d_ack_o(d_ack_o), .rdata_o(rdata_o), .addr_o(addr_o), .data_o(data_o),
        .data_i(data_i), .rd_o(rd_o), .we_o(we_o), .ack_i(ack_i),
        .grant_o(grant_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_acks(input string tag, input logic w, input logic d, input logic i);
        check({tag, "_w_ack"}, {31'h0, w_ack_o}, {31'h0, w});
        check({tag, "_d_ack"}, {31'h0, d_ack_o}, {31'h0, d});
        check({tag, "_i_ack"}, {31'h0, i_ack_o}, {31'h0, i});
    endtask

    initial begin
        rst = 1'b1;
        w_addr_i = 32'h0; i_addr_i = 32'h0; d_addr_i = 32'h0; d_data_i = 32'h0;
        data_i = 32'h0; w_rd_i = 1'b0; i_rd_i = 1'b0; d_rd_i = 1'b0; d_we_i = 1'b0;
        ack_i = 1'b0;
        tick();
        tick();
        check("rst_grant", {30'h0, grant_o}, 32'h0);
        check("rst_rd", {31'h0, rd_o}, 32'h0);
        check("rst_we", {31'h0, we_o}, 32'h0);
        check("rst_addr", addr_o, 32'h0);
        check("rst_data", data_o, 32'h0);
        check("rst_rdata", rdata_o, 32'h0);
        check("rst_err", {31'h0, err_o}, 32'h0);
        check_acks("rst", 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        // Test 1: walker read, ack two cycles after the strobe
        w_rd_i = 1'b1; w_addr_i = 32'h0000_3004;
        tick();
        check("t1_grant", {30'h0, grant_o}, 32'h1);
        check("t1_addr", addr_o, 32'h0000_3004);
        check("t1_rd_c1", {31'h0, rd_o}, 32'h1);
        check("t1_we", {31'h0, we_o}, 32'h0);
        check("t1_data", data_o, 32'h0);
        tick();
        check("t1_rd_c2", {31'h0, rd_o}, 32'h1);
        check_acks("t1_busy", 1'b0, 1'b0, 1'b0);
        ack_i = 1'b1; data_i = 32'h1234_5001;
        tick();
        check_acks("t1_done", 1'b1, 1'b0, 1'b0);
        check("t1_rdata", rdata_o, 32'h1234_5001);
        check("t1_rd_off", {31'h0, rd_o}, 32'h0);
        ack_i = 1'b0; w_rd_i = 1'b0;
        tick();
        check_acks("t1_idle", 1'b0, 1'b0, 1'b0);
        check("t1_grant_idle", {30'h0, grant_o}, 32'h0);

        // Test 2: all three request together -> w, d, i
        w_rd_i = 1'b1; w_addr_i = 32'h0000_0040;
        d_rd_i = 1'b1; d_addr_i = 32'h0000_0080;
        i_rd_i = 1'b1; i_addr_i = 32'h0000_00C0;
        tick();
        check("t2_grant_w", {30'h0, grant_o}, 32'h1);
        check("t2_addr_w", addr_o, 32'h0000_0040);
        ack_i = 1'b1;
        tick();
        check_acks("t2_done_w", 1'b1, 1'b0, 1'b0);
        ack_i = 1'b0; w_rd_i = 1'b0;
        tick();
        check("t2_idle1", {30'h0, grant_o}, 32'h0);
        tick();
        check("t2_grant_d", {30'h0, grant_o}, 32'h2);
        check("t2_addr_d", addr_o, 32'h0000_0080);
        check("t2_rd_d", {31'h0, rd_o}, 32'h1);
        ack_i = 1'b1;
        tick();
        check_acks("t2_done_d", 1'b0, 1'b1, 1'b0);
        ack_i = 1'b0; d_rd_i = 1'b0;
        tick();
        check("t2_idle2", {30'h0, grant_o}, 32'h0);
        tick();
        check("t2_grant_i", {30'h0, grant_o}, 32'h3);
        check("t2_addr_i", addr_o, 32'h0000_00C0);
        ack_i = 1'b1;
        tick();
        check_acks("t2_done_i", 1'b0, 1'b0, 1'b1);
        ack_i = 1'b0; i_rd_i = 1'b0;
        tick();
        check("t2_idle3", {30'h0, grant_o}, 32'h0);

        // Test 3: d and i request continuously, ack_i always high
        d_rd_i = 1'b1; i_rd_i = 1'b1; ack_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("t3_grant", {30'h0, grant_o}, (k % 2 == 0) ? 32'h2 : 32'h3);
            check_acks("t3_busy", 1'b0, 1'b0, 1'b0);
            tick();
            check_acks("t3_done", 1'b0, (k % 2 == 0), (k % 2 == 1));
            tick();
            check_acks("t3_idle", 1'b0, 1'b0, 1'b0);
            check("t3_grant_idle", {30'h0, grant_o}, 32'h0);
        end
        d_rd_i = 1'b0; i_rd_i = 1'b0; ack_i = 1'b0;

        // Test 4: d read+write together becomes a write
        d_rd_i = 1'b1; d_we_i = 1'b1; d_addr_i = 32'h0000_0100; d_data_i = 32'hCAFE_F00D;
        tick();
        check("t4_grant", {30'h0, grant_o}, 32'h2);
        check("t4_we", {31'h0, we_o}, 32'h1);
        check("t4_rd", {31'h0, rd_o}, 32'h0);
        check("t4_data", data_o, 32'hCAFE_F00D);
        check("t4_addr", addr_o, 32'h0000_0100);
        ack_i = 1'b1; data_i = 32'hAAAA_5555;
        tick();
        check_acks("t4_done", 1'b0, 1'b1, 1'b0);
        check("t4_rdata", rdata_o, 32'hAAAA_5555);
        check("t4_we_off", {31'h0, we_o}, 32'h0);
        ack_i = 1'b0; d_rd_i = 1'b0; d_we_i = 1'b0;
        tick();

        // Test 5: reset during BUSY drops the transaction
        i_rd_i = 1'b1; i_addr_i = 32'h0000_0200;
        tick();
        check("t5_grant", {30'h0, grant_o}, 32'h3);
        check("t5_data_i", data_o, 32'h0);
        tick();
        check("t5_rd_busy", {31'h0, rd_o}, 32'h1);
        rst = 1'b1; i_rd_i = 1'b0;
        tick();
        check("t5_rd_rst", {31'h0, rd_o}, 32'h0);
        check("t5_grant_rst", {30'h0, grant_o}, 32'h0);
        check("t5_rdata_rst", rdata_o, 32'h0);
        check_acks("t5_rst", 1'b0, 1'b0, 1'b0);
        rst = 1'b0; ack_i = 1'b1;
        tick();
        check_acks("t5_noack", 1'b0, 1'b0, 1'b0);
        check("t5_grant_idle", {30'h0, grant_o}, 32'h0);
        ack_i = 1'b0;
        i_rd_i = 1'b1; i_addr_i = 32'h0000_0204;
        tick();
        check("t5_regrant", {30'h0, grant_o}, 32'h3);
        check("t5_readdr", addr_o, 32'h0000_0204);
        ack_i = 1'b1; data_i = 32'h0000_5A5A;
        tick();
        check_acks("t5_done", 1'b0, 1'b0, 1'b1);
        check("t5_rdata", rdata_o, 32'h0000_5A5A);
        ack_i = 1'b0; i_rd_i = 1'b0;
        tick();

        // Test 6: no ack_i from the slave
        d_rd_i = 1'b1; d_addr_i = 32'h0000_0300;
        for (int c = 1; c <= 4; c++) begin
            tick();
            check("t6_rd_held", {31'h0, rd_o}, 32'h1);
            check_acks("t6_wait", 1'b0, 1'b0, 1'b0);
        end
        tick();
`ifdef ARB_TIMEOUT_EN
        check_acks("t6_abort", 1'b0, 1'b1, 1'b0);
        check("t6_err", {31'h0, err_o}, 32'h1);
        check("t6_rdata", rdata_o, 32'h0);
        check("t6_rd_off", {31'h0, rd_o}, 32'h0);
        d_rd_i = 1'b0;
        tick();
        check("t6_err_off", {31'h0, err_o}, 32'h0);
        check_acks("t6_idle", 1'b0, 1'b0, 1'b0);
`else
        check("t6_rd_still", {31'h0, rd_o}, 32'h1);
        check_acks("t6_noack", 1'b0, 1'b0, 1'b0);
        check("t6_err", {31'h0, err_o}, 32'h0);
        ack_i = 1'b1; data_i = 32'h0000_0001;
        tick();
        check_acks("t6_done", 1'b0, 1'b1, 1'b0);
        check("t6_rdata", rdata_o, 32'h0000_0001);
        ack_i = 1'b0; d_rd_i = 1'b0;
        tick();
        check("t6_grant_idle", {30'h0, grant_o}, 32'h0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
